// File: rtl/uart_rx_frame_parser_if.sv
// Purpose : bundles the byte stream, the payload read port and the frame status
//           outputs of uart_rx_frame_parser.
// Ports   : rx_data/rx_valid (byte stream in), rd_addr/rd_data (payload buffer read),
//           frame_valid/frame_cmd/frame_len (good-frame report),
//           err_chk/err_len/err_timeout (error pulses).
//           master = producer of the byte stream and reader of the buffer; slave = parser.
interface uart_rx_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [7:0] frame_cmd;
  logic [7:0] frame_len;
  logic       err_chk;
  logic       err_len;
  logic       err_timeout;

  modport master (
    output rx_data, rx_valid, rd_addr,
    input  rd_data, frame_valid, frame_cmd, frame_len, err_chk, err_len, err_timeout
  );

  modport slave (
    input  rx_data, rx_valid, rd_addr,
    output rd_data, frame_valid, frame_cmd, frame_len, err_chk, err_len, err_timeout
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Purpose : recognise HDR0 HDR1 CMD LEN payload CHK frames in a UART byte stream,
//           verify length and 8-bit checksum, store the payload in a readable buffer.
// Latency : status pulses one cycle after the deciding byte; rd_data one cycle after rd_addr.
// Backpressure: none - the receiver cannot be stalled, a byte is consumed on every rx_valid.
// Ports   : clk, rst (sync, active-high); bus (slave modport) carries rx_data/rx_valid,
//           rd_addr/rd_data, frame_valid/frame_cmd/frame_len and the three error pulses.
module uart_rx_frame_parser #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 1000,
  parameter logic [7:0]  HDR0    = 8'h55,
  parameter logic [7:0]  HDR1    = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_rx_frame_parser_if.slave bus
);

  localparam int unsigned   AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
  localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);
  // Counter value seen in the TIMEOUT-th idle cycle after the last byte.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_SAT   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    cmd_tmp_q, cmd_tmp_d;
  logic [7:0]    len_tmp_q, len_tmp_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    frame_cmd_q, frame_cmd_d;
  logic [7:0]    frame_len_q, frame_len_d;
  logic          frame_valid_q, frame_valid_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_tmo_q, err_tmo_d;
  logic [7:0]    rd_data_q;
  logic          wr_en;
  logic          tmo_expired;

  logic [7:0]    mem [MAX_LEN];

  // A byte in the expiry cycle wins, so expiry requires rx_valid low.
  assign tmo_expired = (state_q != S_IDLE) && !bus.rx_valid && (tmo_q == TMO_LAST);

  always_comb begin
    state_d       = state_q;
    sum_d         = sum_q;
    cmd_tmp_d     = cmd_tmp_q;
    len_tmp_d     = len_tmp_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    frame_cmd_d   = frame_cmd_q;
    frame_len_d   = frame_len_q;
    frame_valid_d = 1'b0;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_tmo_d     = 1'b0;
    wr_en         = 1'b0;

    if (bus.rx_valid) begin
      tmo_d = '0;
    end else if ((state_q != S_IDLE) && (tmo_q != TMO_SAT)) begin
      tmo_d = tmo_q + TW'(1);
    end

    if (bus.rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_data == HDR0) state_d = S_HDR1;
        end
        S_HDR1: begin
          // A repeated HDR0 may be the real start of a frame, so keep waiting for HDR1.
          if (bus.rx_data == HDR1)      state_d = S_CMD;
          else if (bus.rx_data != HDR0) state_d = S_IDLE;
        end
        S_CMD: begin
          cmd_tmp_d = bus.rx_data;
          sum_d     = bus.rx_data;
          state_d   = S_LEN;
        end
        S_LEN: begin
          len_tmp_d = bus.rx_data;
          sum_d     = sum_q + bus.rx_data;
          idx_d     = '0;
          if ({1'b0, bus.rx_data} > MAX_LEN_W) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else if (bus.rx_data == 8'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          wr_en = 1'b1;
          sum_d = sum_q + bus.rx_data;
          idx_d = idx_q + 8'd1;
          if (idx_q == len_tmp_q - 8'd1) state_d = S_CHK;
        end
        S_CHK: begin
          if (bus.rx_data == sum_q) begin
            frame_valid_d = 1'b1;
            frame_cmd_d   = cmd_tmp_q;
            frame_len_d   = len_tmp_q;
          end else begin
            err_chk_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_expired) begin
      err_tmo_d = 1'b1;
      state_d   = S_IDLE;
      tmo_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sum_q         <= '0;
      cmd_tmp_q     <= '0;
      len_tmp_q     <= '0;
      idx_q         <= '0;
      tmo_q         <= '0;
      frame_cmd_q   <= '0;
      frame_len_q   <= '0;
      frame_valid_q <= 1'b0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_tmo_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      cmd_tmp_q     <= cmd_tmp_d;
      len_tmp_q     <= len_tmp_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      frame_cmd_q   <= frame_cmd_d;
      frame_len_q   <= frame_len_d;
      frame_valid_q <= frame_valid_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_tmo_q     <= err_tmo_d;
    end
  end

  // Payload storage is deliberately not reset; only the write is blocked during reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[idx_q[AW-1:0]] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if ({1'b0, bus.rd_addr} < MAX_LEN_W) begin
      rd_data_q <= mem[bus.rd_addr[AW-1:0]];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_cmd   = frame_cmd_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_tmo_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
`timescale 1ns/1ps
module tb_uart_rx_frame_parser;
  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 1000;
  localparam logic [7:0] HDR0    = 8'h55;
  localparam logic [7:0] HDR1    = 8'hAA;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_frame_parser_if bus ();

  uart_rx_frame_parser #(
    .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .HDR0(HDR0), .HDR1(HDR1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Pulse log: mask bit0 frame_valid, bit1 err_chk, bit2 err_len, bit3 err_timeout.
  bit         mon_en = 1'b0;
  int         ev_cyc[$];
  logic [3:0] ev_mask[$];
  int         exp_cyc[$];
  logic [3:0] exp_mask[$];

  always @(negedge clk) begin
    logic [3:0] m;
    m = {bus.err_timeout, bus.err_len, bus.err_chk, bus.frame_valid};
    if (mon_en && (m !== 4'b0000)) begin
      ev_cyc.push_back(cyc);
      ev_mask.push_back(m);
    end
  end

  // Reference state: last good frame and the buffer as the byte stream leaves it.
  logic [7:0] mdl_cmd = 8'h00;
  logic [7:0] mdl_len = 8'h00;
  logic [7:0] mdl_buf [MAX_LEN];
  logic [7:0] sb[$];
  int         sc[$];

  task automatic send(input logic [7:0] b, output int c);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    c = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  // Frame-level scan of a complete byte list that starts with the parser idle.
  task automatic model_scan();
    int i, j, k, n, len;
    logic [7:0] s;
    i = 0;
    n = sb.size();
    while (i < n) begin
      if (sb[i] !== HDR0) begin i++; continue; end
      j = i + 1;
      while (j < n && sb[j] === HDR0) j++;
      if (j >= n) break;
      if (sb[j] !== HDR1) begin i = j + 1; continue; end
      if (j + 2 >= n) break;
      len = int'(sb[j+2]);
      if (len > MAX_LEN) begin
        exp_cyc.push_back(sc[j+2] + 1); exp_mask.push_back(4'b0100);
        i = j + 3;
        continue;
      end
      k = j + 3 + len;
      if (k >= n) break;
      s = sb[j+1] + sb[j+2];
      for (int p = 0; p < len; p++) begin
        s = s + sb[j+3+p];
        mdl_buf[p] = sb[j+3+p];
      end
      if (sb[k] === s) begin
        exp_cyc.push_back(sc[k] + 1); exp_mask.push_back(4'b0001);
        mdl_cmd = sb[j+1];
        mdl_len = sb[j+2];
      end else begin
        exp_cyc.push_back(sc[k] + 1); exp_mask.push_back(4'b0010);
      end
      i = k + 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rd_addr = 8'h00;
    repeat (3) @(negedge clk);
    vectors++; if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_frame_valid: got %b want 0", bus.frame_valid); end
    vectors++; if (bus.err_chk !== 1'b0) begin miscompares++; $display("FAIL reset_err_chk: got %b want 0", bus.err_chk); end
    vectors++; if (bus.err_len !== 1'b0) begin miscompares++; $display("FAIL reset_err_len: got %b want 0", bus.err_len); end
    vectors++; if (bus.err_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_err_timeout: got %b want 0", bus.err_timeout); end
    vectors++; if (bus.frame_cmd !== 8'h00) begin miscompares++; $display("FAIL reset_frame_cmd: got %h want 00", bus.frame_cmd); end
    vectors++; if (bus.frame_len !== 8'h00) begin miscompares++; $display("FAIL reset_frame_len: got %h want 00", bus.frame_len); end
    vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    logic [7:0] f[8];
    logic [7:0] want[3];
    int c;
    f = '{8'h55, 8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
    want = '{8'h10, 8'h20, 8'h30};
    foreach (f[i]) send(f[i], c);
    exp_cyc.push_back(c + 1); exp_mask.push_back(4'b0001);
    idle(3);
    vectors++;
    if (ev_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL good_events: %0d pulses seen, %0d expected", ev_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < ev_cyc.size(); i++) begin
      vectors++;
      if (ev_cyc[i] !== exp_cyc[i] || ev_mask[i] !== exp_mask[i]) begin
        miscompares++;
        $display("FAIL good_event%0d: cycle %0d mask %b, expected cycle %0d mask %b", i, ev_cyc[i], ev_mask[i], exp_cyc[i], exp_mask[i]);
      end
    end
    ev_cyc.delete(); ev_mask.delete(); exp_cyc.delete(); exp_mask.delete();
    vectors++; if (bus.frame_cmd !== 8'h01) begin miscompares++; $display("FAIL good_cmd: got %h want 01", bus.frame_cmd); end
    vectors++; if (bus.frame_len !== 8'h03) begin miscompares++; $display("FAIL good_len: got %h want 03", bus.frame_len); end
    for (int a = 0; a < 3; a++) begin
      bus.rd_addr = 8'(a);
      @(negedge clk);
      vectors++;
      if (bus.rd_data !== want[a]) begin miscompares++; $display("FAIL good_rd%0d: got %h want %h", a, bus.rd_data, want[a]); end
    end
    bus.rd_addr = 8'(MAX_LEN);
    @(negedge clk);
    vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL rd_out_of_range: got %h want 00", bus.rd_data); end
    bus.rd_addr = 8'hFF;
    @(negedge clk);
    vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL rd_addr_ff: got %h want 00", bus.rd_data); end
    mdl_cmd = 8'h01; mdl_len = 8'h03;
    for (int p = 0; p < 3; p++) mdl_buf[p] = want[p];
  endtask

  task automatic test_bad_chk();
    logic [7:0] f[8];
    int c;
    f = '{8'h55, 8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h65};
    foreach (f[i]) send(f[i], c);
    exp_cyc.push_back(c + 1); exp_mask.push_back(4'b0010);
    idle(3);
    vectors++;
    if (ev_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL badchk_events: %0d pulses seen, %0d expected", ev_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < ev_cyc.size(); i++) begin
      vectors++;
      if (ev_cyc[i] !== exp_cyc[i] || ev_mask[i] !== exp_mask[i]) begin
        miscompares++;
        $display("FAIL badchk_event%0d: cycle %0d mask %b, expected cycle %0d mask %b", i, ev_cyc[i], ev_mask[i], exp_cyc[i], exp_mask[i]);
      end
    end
    ev_cyc.delete(); ev_mask.delete(); exp_cyc.delete(); exp_mask.delete();
    vectors++; if (bus.frame_cmd !== mdl_cmd) begin miscompares++; $display("FAIL badchk_cmd_held: got %h want %h", bus.frame_cmd, mdl_cmd); end
    vectors++; if (bus.frame_len !== mdl_len) begin miscompares++; $display("FAIL badchk_len_held: got %h want %h", bus.frame_len, mdl_len); end
  endtask

  task automatic test_len_err();
    logic [7:0] f[9];
    int c;
    f = '{8'h55, 8'hAA, 8'h02, 8'h11, 8'h55, 8'hAA, 8'h02, 8'h00, 8'h02};
    foreach (f[i]) begin
      send(f[i], c);
      if (i == 3) begin exp_cyc.push_back(c + 1); exp_mask.push_back(4'b0100); end
      if (i == 8) begin exp_cyc.push_back(c + 1); exp_mask.push_back(4'b0001); end
    end
    idle(3);
    vectors++;
    if (ev_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL lenerr_events: %0d pulses seen, %0d expected", ev_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < ev_cyc.size(); i++) begin
      vectors++;
      if (ev_cyc[i] !== exp_cyc[i] || ev_mask[i] !== exp_mask[i]) begin
        miscompares++;
        $display("FAIL lenerr_event%0d: cycle %0d mask %b, expected cycle %0d mask %b", i, ev_cyc[i], ev_mask[i], exp_cyc[i], exp_mask[i]);
      end
    end
    ev_cyc.delete(); ev_mask.delete(); exp_cyc.delete(); exp_mask.delete();
    vectors++; if (bus.frame_cmd !== 8'h02) begin miscompares++; $display("FAIL lenerr_cmd: got %h want 02", bus.frame_cmd); end
    vectors++; if (bus.frame_len !== 8'h00) begin miscompares++; $display("FAIL lenerr_len0: got %h want 00", bus.frame_len); end
    mdl_cmd = 8'h02; mdl_len = 8'h00;
  endtask

  task automatic test_timeout();
    logic [7:0] tail[5];
    logic [7:0] f2[4];
    int c;
    tail = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
    // Gap of exactly TIMEOUT idle cycles expires; the stray bytes after it must be ignored.
    send(8'h55, c); send(8'hAA, c); send(8'h01, c);
    exp_cyc.push_back(c + TIMEOUT + 1); exp_mask.push_back(4'b1000);
    idle(TIMEOUT + 10);
    foreach (tail[i]) send(tail[i], c);
    idle(3);
    // A byte landing in the last allowed cycle keeps the frame alive.
    send(8'h55, c); send(8'hAA, c); send(8'h01, c);
    idle(TIMEOUT - 1);
    f2 = '{8'h02, 8'hAB, 8'hCD, 8'h7B};
    foreach (f2[i]) send(f2[i], c);
    exp_cyc.push_back(c + 1); exp_mask.push_back(4'b0001);
    idle(3);
    vectors++;
    if (ev_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL timeout_events: %0d pulses seen, %0d expected", ev_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < ev_cyc.size(); i++) begin
      vectors++;
      if (ev_cyc[i] !== exp_cyc[i] || ev_mask[i] !== exp_mask[i]) begin
        miscompares++;
        $display("FAIL timeout_event%0d: cycle %0d mask %b, expected cycle %0d mask %b", i, ev_cyc[i], ev_mask[i], exp_cyc[i], exp_mask[i]);
      end
    end
    ev_cyc.delete(); ev_mask.delete(); exp_cyc.delete(); exp_mask.delete();
    vectors++; if (bus.frame_len !== 8'h02) begin miscompares++; $display("FAIL timeout_edge_len: got %h want 02", bus.frame_len); end
    mdl_cmd = 8'h01; mdl_len = 8'h02; mdl_buf[0] = 8'hAB; mdl_buf[1] = 8'hCD;
  endtask

  task automatic test_back_to_back();
    logic [7:0] f[8];
    int c;
    f = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h07, 8'h01, 8'h5A, 8'h62};
    foreach (f[i]) send(f[i], c);
    exp_cyc.push_back(c + 1); exp_mask.push_back(4'b0001);
    idle(3);
    vectors++;
    if (ev_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL b2b_events: %0d pulses seen, %0d expected", ev_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < ev_cyc.size(); i++) begin
      vectors++;
      if (ev_cyc[i] !== exp_cyc[i] || ev_mask[i] !== exp_mask[i]) begin
        miscompares++;
        $display("FAIL b2b_event%0d: cycle %0d mask %b, expected cycle %0d mask %b", i, ev_cyc[i], ev_mask[i], exp_cyc[i], exp_mask[i]);
      end
    end
    ev_cyc.delete(); ev_mask.delete(); exp_cyc.delete(); exp_mask.delete();
    vectors++; if (bus.frame_cmd !== 8'h07) begin miscompares++; $display("FAIL b2b_cmd: got %h want 07", bus.frame_cmd); end
    vectors++; if (bus.frame_len !== 8'h01) begin miscompares++; $display("FAIL b2b_len: got %h want 01", bus.frame_len); end
    bus.rd_addr = 8'h00;
    @(negedge clk);
    vectors++; if (bus.rd_data !== 8'h5A) begin miscompares++; $display("FAIL b2b_buf0: got %h want 5a", bus.rd_data); end
    mdl_cmd = 8'h07; mdl_len = 8'h01; mdl_buf[0] = 8'h5A;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] f[5];
    logic [7:0] g[7];
    int c;
    f = '{8'h55, 8'hAA, 8'h01, 8'h03, 8'h10};
    foreach (f[i]) send(f[i], c);
    @(negedge clk);
    rst = 1'b1; bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.frame_cmd !== 8'h00) begin miscompares++; $display("FAIL midrst_cmd: got %h want 00", bus.frame_cmd); end
    vectors++; if (bus.frame_len !== 8'h00) begin miscompares++; $display("FAIL midrst_len: got %h want 00", bus.frame_len); end
    vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL midrst_rd_data: got %h want 00", bus.rd_data); end
    rst = 1'b0;
    idle(TIMEOUT + 5);
    vectors++; if (ev_cyc.size() != 0) begin miscompares++; $display("FAIL midrst_no_pulse: %0d pulses seen, 0 expected", ev_cyc.size()); end
    ev_cyc.delete(); ev_mask.delete();
    mdl_cmd = 8'h00; mdl_len = 8'h00; mdl_buf[0] = 8'h10;
    g = '{8'h55, 8'hAA, 8'h05, 8'h02, 8'h11, 8'h22, 8'h3A};
    foreach (g[i]) send(g[i], c);
    exp_cyc.push_back(c + 1); exp_mask.push_back(4'b0001);
    idle(3);
    vectors++;
    if (ev_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL midrst_after_events: %0d pulses seen, %0d expected", ev_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < ev_cyc.size(); i++) begin
      vectors++;
      if (ev_cyc[i] !== exp_cyc[i] || ev_mask[i] !== exp_mask[i]) begin
        miscompares++;
        $display("FAIL midrst_event%0d: cycle %0d mask %b, expected cycle %0d mask %b", i, ev_cyc[i], ev_mask[i], exp_cyc[i], exp_mask[i]);
      end
    end
    ev_cyc.delete(); ev_mask.delete(); exp_cyc.delete(); exp_mask.delete();
    vectors++; if (bus.frame_cmd !== 8'h05) begin miscompares++; $display("FAIL midrst_after_cmd: got %h want 05", bus.frame_cmd); end
    mdl_cmd = 8'h05; mdl_len = 8'h02; mdl_buf[0] = 8'h11; mdl_buf[1] = 8'h22;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int kind, len, c;
      logic [7:0] x, s, cmd;
      sb.delete(); sc.delete();
      kind = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) begin
        x = 8'($urandom_range(0, 255));
        if (x == HDR0) x = 8'h00;
        sb.push_back(x);
      end
      sb.push_back(HDR0);
      if ($urandom_range(0, 3) == 0) sb.push_back(HDR0);
      sb.push_back(HDR1);
      cmd = 8'($urandom_range(0, 255));
      len = (kind == 2) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, MAX_LEN);
      sb.push_back(cmd);
      sb.push_back(8'(len));
      if (kind != 2) begin
        s = cmd + 8'(len);
        for (int p = 0; p < len; p++) begin
          x = 8'($urandom_range(0, 255));
          sb.push_back(x);
          s = s + x;
        end
        sb.push_back((kind == 0) ? s : s + 8'($urandom_range(1, 255)));
      end
      foreach (sb[i]) begin
        send(sb[i], c);
        sc.push_back(c);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
      end
      idle(3);
      model_scan();
      vectors++;
      if (ev_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL rand%0d_events: %0d pulses seen, %0d expected", n, ev_cyc.size(), exp_cyc.size()); end
      for (int i = 0; i < exp_cyc.size() && i < ev_cyc.size(); i++) begin
        vectors++;
        if (ev_cyc[i] !== exp_cyc[i] || ev_mask[i] !== exp_mask[i]) begin
          miscompares++;
          $display("FAIL rand%0d_event%0d: cycle %0d mask %b, expected cycle %0d mask %b", n, i, ev_cyc[i], ev_mask[i], exp_cyc[i], exp_mask[i]);
        end
      end
      ev_cyc.delete(); ev_mask.delete(); exp_cyc.delete(); exp_mask.delete();
      vectors++; if (bus.frame_cmd !== mdl_cmd) begin miscompares++; $display("FAIL rand%0d_cmd: got %h want %h", n, bus.frame_cmd, mdl_cmd); end
      vectors++; if (bus.frame_len !== mdl_len) begin miscompares++; $display("FAIL rand%0d_len: got %h want %h", n, bus.frame_len, mdl_len); end
      if (kind == 0) begin
        for (int a = 0; a < len; a++) begin
          bus.rd_addr = 8'(a);
          @(negedge clk);
          vectors++;
          if (bus.rd_data !== mdl_buf[a]) begin miscompares++; $display("FAIL rand%0d_rd%0d: got %h want %h", n, a, bus.rd_data, mdl_buf[a]); end
        end
        bus.rd_addr = 8'($urandom_range(MAX_LEN, 255));
        @(negedge clk);
        vectors++;
        if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL rand%0d_rd_oob: addr %h got %h want 00", n, bus.rd_addr, bus.rd_data); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
